// File: rtl/lsu_mem_stage_if.sv
// Memory-side bus of the load/store stage.
// Handshake: the stage raises mem_req together with mem_we, mem_addr,
// mem_be and mem_wdata. It holds all of them stable until a cycle in which
// mem_ack is high, and that cycle completes the transfer. On loads,
// mem_rdata must be valid in the ack cycle. The stage samples mem_ack only
// while it has a request outstanding, so an ack at any other time is ignored.
interface lsu_mem_stage_if #(
    parameter int MEM_ADDR_W = 13
);
    logic                  mem_req;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32 load/store memory stage. It checks funct3 and alignment, builds byte
// enables and lane-replicated store data, and runs one request at a time on
// the valid/ack memory bus while stalling the pipeline. It sign/zero-extends
// load data and has an optional wait-state watchdog (MAX_WAIT = 0 disables it).
module lsu_mem_stage #(
    parameter int MEM_ADDR_W = 13,
    parameter int MAX_WAIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_addr,
    output logic        dbg_state,
    lsu_mem_stage_if.master mem
);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT3   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // The counter only has to reach MAX_WAIT-1. That last BUSY cycle without
    // an ack is the timeout cycle.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q;
    logic [2:0]       ld_f3_q;
    logic [1:0]       ld_off_q;
    logic [31:0]      req_addr_q;

    logic        is_access, f3_legal, misaligned, accept, reject;
    logic        ack_seen, timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, ld_shift, ld_ext;

    assign is_access  = in_valid & (memread | memwrite);
    assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                        ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    assign accept     = (state_q == IDLE) & is_access & f3_legal & ~misaligned;
    assign reject     = (state_q == IDLE) & is_access & ~(f3_legal & ~misaligned);
    assign ack_seen   = (state_q == BUSY) & mem.mem_ack;
    assign timeout    = (MAX_WAIT > 0) & (state_q == BUSY) & ~mem.mem_ack & (wait_q == WAIT_LAST);
    assign mem.mem_req = (state_q == BUSY);
    assign dbg_state   = state_q;

    // funct3 legality: unsigned loads exist, unsigned stores do not; memwrite wins
    always_comb begin
        f3_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = ~memwrite;
            default:                f3_legal = 1'b0;
        endcase
    end

    // Byte enables and lane-replicated store data; loads read the whole word
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wdata;
        if (memwrite) begin
            case (funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = wdata;
                end
            endcase
        end
    end

    // Lane select and sign/zero extension of the returned word
    always_comb begin
        ld_shift = mem.mem_rdata >> {ld_off_q, 3'b000};
        ld_ext   = mem.mem_rdata;
        case (ld_f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and stall: hold upstream until the ack or timeout cycle
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    stall   = 1'b1;
                end
            end
            BUSY: begin
                if (ack_seen || timeout) state_d = IDLE;
                else                     stall   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Wait-state counter, cleared whenever a new request is launched
    always_ff @(posedge clk) begin
        if (rst)                               wait_q <= '0;
        else if (accept)                       wait_q <= '0;
        else if (state_q == BUSY && !mem.mem_ack) wait_q <= wait_q + 1'b1;
    end

    // Request capture, load result and fault pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'b0000;
            mem.mem_wdata <= 32'd0;
            ld_f3_q       <= 3'b000;
            ld_off_q      <= 2'b00;
            req_addr_q    <= 32'd0;
            rdata         <= 32'd0;
            rdata_valid   <= 1'b0;
            fault         <= 1'b0;
            fault_cause   <= 2'b00;
            fault_addr    <= 32'd0;
        end else begin
            rdata_valid <= 1'b0;
            fault       <= 1'b0;
            if (accept) begin
                mem.mem_we    <= memwrite;
                mem.mem_addr  <= addr[MEM_ADDR_W+1:2];
                mem.mem_be    <= be_d;
                mem.mem_wdata <= wdata_d;
                ld_f3_q       <= funct3;
                ld_off_q      <= addr[1:0];
                req_addr_q    <= addr;
            end
            if (reject) begin
                fault       <= 1'b1;
                fault_cause <= f3_legal ? CAUSE_MISALIGN : CAUSE_FUNCT3;
                fault_addr  <= addr;
            end
            if (timeout) begin
                fault       <= 1'b1;
                fault_cause <= CAUSE_TIMEOUT;
                fault_addr  <= req_addr_q;
            end
            if (ack_seen && !mem.mem_we) begin
                rdata       <= ld_ext;
                rdata_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage with MAX_WAIT=4 and a responder whose ack delay can be programmed.
module tb_lsu_mem_stage;
    localparam int MW   = 13;
    localparam int MAXW = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, memread, memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, fault, dbg_state;
    logic [31:0] rdata, fault_addr;
    logic [1:0]  fault_cause;

    lsu_mem_stage_if #(.MEM_ADDR_W(MW)) mem_bus ();

    lsu_mem_stage #(.MEM_ADDR_W(MW), .MAX_WAIT(MAXW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .memread     (memread),
        .memwrite    (memwrite),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_addr  (fault_addr),
        .dbg_state   (dbg_state),
        .mem         (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // ---------------- memory responder ----------------
    int          ack_delay  = 0;
    int          req_cnt    = 0;
    logic        manual_ack = 1'b0;
    logic [31:0] mem_word   = 32'd0;

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!manual_ack) begin
                if (mem_bus.mem_req === 1'b1) begin
                    mem_bus.mem_ack = (req_cnt == ack_delay);
                    req_cnt++;
                end else begin
                    mem_bus.mem_ack = 1'b0;
                    req_cnt = 0;
                end
                mem_bus.mem_rdata = mem_word;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rdata_unexpected got=%h exp=none", rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL rdata got=%h exp=%h", rdata, e);
                end
            end
        end
    end

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[int'(a[1:0]) * 8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // ---------------- driver and observation ----------------
    int              t0, o_stall, o_req, o_rv, o_rv_lat, o_fault, o_fault_lat;
    logic [1:0]      o_cause;
    logic [31:0]     o_faddr, o_wdata;
    logic            o_stable, o_we;
    logic [MW-1:0]   o_addr;
    logic [3:0]      o_be;

    task automatic observe();
        if (stall === 1'b1) o_stall++;
        if (mem_bus.mem_req === 1'b1) begin
            if (o_req == 0) begin
                o_addr  = mem_bus.mem_addr;
                o_be    = mem_bus.mem_be;
                o_wdata = mem_bus.mem_wdata;
                o_we    = mem_bus.mem_we;
            end else if (mem_bus.mem_addr !== o_addr || mem_bus.mem_be !== o_be ||
                         mem_bus.mem_wdata !== o_wdata || mem_bus.mem_we !== o_we) begin
                o_stable = 1'b0;
            end
            o_req++;
        end
        if (rdata_valid === 1'b1) begin
            if (o_rv == 0) o_rv_lat = cyc - t0;
            o_rv++;
        end
        if (fault === 1'b1) begin
            if (o_fault == 0) begin
                o_fault_lat = cyc - t0;
                o_cause     = fault_cause;
                o_faddr     = fault_addr;
            end
            o_fault++;
        end
    endtask

    // Present one instruction, hold it while stalled, then watch three more cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] word, input int delay);
        logic st;
        int   i;
        o_stall = 0; o_req = 0; o_rv = 0; o_rv_lat = -1; o_fault = 0; o_fault_lat = -1;
        o_cause = 2'b00; o_faddr = 32'd0; o_stable = 1'b1;
        o_addr = '0; o_be = 4'b0000; o_wdata = 32'd0; o_we = 1'b0;
        ack_delay = delay;
        mem_word  = word;
        in_valid = 1'b1; memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
        t0 = cyc;
        st = 1'b1;
        i  = 0;
        while (st && i < 40) begin
            @(negedge clk);
            observe();
            st = stall;
            @(posedge clk);
            #1;
            i++;
        end
        if (st) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_bound stall still high after %0d cycles", i);
        end
        in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
        repeat (3) begin
            @(negedge clk);
            observe();
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; memread = 1'b0; memwrite = 1'b0;
        funct3 = 3'b000; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({stall, mem_bus.mem_req, rdata_valid, fault, dbg_state} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=00000", {stall, mem_bus.mem_req, rdata_valid, fault, dbg_state});
        end
        n_checks++;
        if (rdata !== 32'd0 || fault_addr !== 32'd0 || fault_cause !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data got rdata=%h faddr=%h cause=%b exp=0", rdata, fault_addr, fault_cause);
        end
        n_checks++;
        if (mem_bus.mem_be !== 4'b0000 || mem_bus.mem_wdata !== 32'd0 || mem_bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bus got be=%b wdata=%h we=%b exp=0", mem_bus.mem_be, mem_bus.mem_wdata, mem_bus.mem_we);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_stores();
        logic [2:0]  f3[3]  = '{3'b000, 3'b001, 3'b010};
        logic [31:0] a[3]   = '{32'h103, 32'h102, 32'h104};
        logic [31:0] wd[3]  = '{32'hAABBCCDD, 32'h12345678, 32'hCAFEF00D};
        logic [MW-1:0] ea[3] = '{13'h40, 13'h40, 13'h41};
        logic [3:0]  eb[3]  = '{4'b1000, 4'b1100, 4'b1111};
        logic [31:0] ew[3]  = '{32'hDDDDDDDD, 32'h56785678, 32'hCAFEF00D};
        for (int k = 0; k < 3; k++) begin
            run_access(1'b0, 1'b1, f3[k], a[k], wd[k], 32'd0, 0);
            n_checks++;
            if (o_addr !== ea[k] || o_be !== eb[k] || o_wdata !== ew[k] || o_we !== 1'b1) begin
                n_fail++;
                $display("FAIL store%0d_bus got addr=%h be=%b wdata=%h we=%b exp addr=%h be=%b wdata=%h we=1",
                         k, o_addr, o_be, o_wdata, o_we, ea[k], eb[k], ew[k]);
            end
            n_checks++;
            if (o_stall !== 1 || o_req !== 1 || o_rv !== 0 || o_fault !== 0) begin
                n_fail++;
                $display("FAIL store%0d_timing got stall=%0d req=%0d rv=%0d fault=%0d exp 1 1 0 0",
                         k, o_stall, o_req, o_rv, o_fault);
            end
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3[9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b000, 3'b100};
        logic [31:0] a[9]  = '{32'h102, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h100, 32'h103, 32'h101};
        logic [31:0] e[9]  = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01,
                               32'h00000001, 32'h00007F01, 32'hFFFFFF80, 32'h0000007F};
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(e[k]);
            run_access(1'b1, 1'b0, f3[k], a[k], 32'd0, 32'h80FF7F01, 0);
            n_checks++;
            if (o_rv_lat !== 2 || o_rv !== 1 || o_stall !== 1) begin
                n_fail++;
                $display("FAIL load%0d_timing got lat=%0d pulses=%0d stall=%0d exp 2 1 1", k, o_rv_lat, o_rv, o_stall);
            end
            n_checks++;
            if (o_we !== 1'b0 || o_be !== 4'b1111 || o_addr !== a[k][MW+1:2]) begin
                n_fail++;
                $display("FAIL load%0d_bus got we=%b be=%b addr=%h exp we=0 be=1111 addr=%h", k, o_we, o_be, o_addr, a[k][MW+1:2]);
            end
        end
    endtask

    task automatic test_rejects();
        logic        rd[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3[7] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b110};
        logic [31:0] a[7]  = '{32'h106, 32'h101, 32'h102, 32'h100, 32'h101, 32'h100, 32'h200};
        logic [1:0]  ec[7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
        for (int k = 0; k < 7; k++) begin
            run_access(rd[k], ~rd[k], f3[k], a[k], 32'h5555AAAA, 32'd0, 0);
            n_checks++;
            if (o_fault !== 1 || o_fault_lat !== 1 || o_cause !== ec[k] || o_faddr !== a[k]) begin
                n_fail++;
                $display("FAIL reject%0d_fault got n=%0d lat=%0d cause=%b addr=%h exp 1 1 %b %h",
                         k, o_fault, o_fault_lat, o_cause, o_faddr, ec[k], a[k]);
            end
            n_checks++;
            if (o_req !== 0 || o_stall !== 0 || o_rv !== 0) begin
                n_fail++;
                $display("FAIL reject%0d_quiet got req=%0d stall=%0d rv=%0d exp 0 0 0", k, o_req, o_stall, o_rv);
            end
        end
    endtask

    task automatic test_non_access();
        run_access(1'b0, 1'b0, 3'b010, 32'h106, 32'd0, 32'd0, 0);
        n_checks++;
        if (o_req !== 0 || o_stall !== 0 || o_fault !== 0 || o_rv !== 0) begin
            n_fail++;
            $display("FAIL non_access got req=%0d stall=%0d fault=%0d rv=%0d exp 0 0 0 0", o_req, o_stall, o_fault, o_rv);
        end
    endtask

    task automatic test_wait_states();
        exp_q.push_back(32'h13579BDF);
        run_access(1'b1, 1'b0, 3'b010, 32'h1F0, 32'd0, 32'h13579BDF, 3);
        n_checks++;
        if (o_stall !== 4 || o_rv_lat !== 5 || o_req !== 4 || o_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_states got stall=%0d lat=%0d req=%0d stable=%b exp 4 5 4 1", o_stall, o_rv_lat, o_req, o_stable);
        end
        n_checks++;
        if (o_addr !== 13'h7C || o_be !== 4'b1111) begin
            n_fail++;
            $display("FAIL wait_bus got addr=%h be=%b exp 7c 1111", o_addr, o_be);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 32'hDEADBEEF, 1000);
        n_checks++;
        if (o_req !== MAXW || o_stall !== MAXW || o_rv !== 0) begin
            n_fail++;
            $display("FAIL timeout_req got req=%0d stall=%0d rv=%0d exp %0d %0d 0", o_req, o_stall, o_rv, MAXW, MAXW);
        end
        n_checks++;
        if (o_fault !== 1 || o_cause !== 2'b11 || o_faddr !== 32'h108 || o_fault_lat !== MAXW + 1) begin
            n_fail++;
            $display("FAIL timeout_fault got n=%0d cause=%b addr=%h lat=%0d exp 1 11 108 %0d",
                     o_fault, o_cause, o_faddr, o_fault_lat, MAXW + 1);
        end
        ack_delay = 0;
    endtask

    task automatic test_back_to_back();
        logic st;
        int   i, tb_cyc, rv_after, lat_b;
        mem_word = 32'hA1B2C3D4;
        ack_delay = 0;
        exp_q.push_back(32'hA1B2C3D4);
        in_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h300; wdata = 32'd0;
        st = 1'b1;
        i  = 0;
        while (st && i < 20) begin
            @(negedge clk);
            st = stall;
            @(posedge clk);
            #1;
            i++;
        end
        exp_q.push_back(32'h000000A1);
        funct3 = 3'b100; addr = 32'h303;
        tb_cyc = cyc;
        @(negedge clk);
        n_checks++;
        if (stall !== 1'b1 || rdata_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_overlap got stall=%b rdata_valid=%b exp 1 1", stall, rdata_valid);
        end
        @(posedge clk);
        #1;
        i = 0;
        st = 1'b1;
        rv_after = 0;
        lat_b = -1;
        while (i < 6) begin
            @(negedge clk);
            if (rdata_valid === 1'b1) begin
                rv_after++;
                lat_b = cyc - tb_cyc;
            end
            st = stall;
            @(posedge clk);
            #1;
            if (!st) begin
                in_valid = 1'b0; memread = 1'b0;
            end
            i++;
        end
        n_checks++;
        if (rv_after !== 1 || lat_b !== 2) begin
            n_fail++;
            $display("FAIL b2b_second got pulses=%0d lat=%0d exp 1 2", rv_after, lat_b);
        end
    endtask

    task automatic test_random();
        logic [2:0]  lf3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [31:0] a, w;
        int          d;
        for (int k = 0; k < 10; k++) begin
            f3 = lf3[$urandom_range(0, 4)];
            a  = $urandom_range(0, 32'h7FFF);
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            w  = $urandom;
            d  = $urandom_range(0, 2);
            exp_q.push_back(exp_load(f3, a, w));
            run_access(1'b1, 1'b0, f3, a, 32'd0, w, d);
            n_checks++;
            if (o_rv_lat !== 2 + d || o_stall !== 1 + d || o_addr !== a[MW+1:2]) begin
                n_fail++;
                $display("FAIL rand%0d got lat=%0d stall=%0d addr=%h exp %0d %0d %h",
                         k, o_rv_lat, o_stall, o_addr, 2 + d, 1 + d, a[MW+1:2]);
            end
        end
    endtask

    task automatic test_reset_busy();
        manual_ack = 1'b1;
        mem_bus.mem_ack = 1'b0;
        in_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0; memread = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstbusy_pre got mem_req=%b exp 1", mem_bus.mem_req);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'h77777777;
        @(negedge clk);
        n_checks++;
        if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0 || dbg_state !== 1'b0) begin
            n_fail++;
            $display("FAIL rstbusy_post got req=%b stall=%b state=%b exp 0 0 0", mem_bus.mem_req, stall, dbg_state);
        end
        @(posedge clk);
        #1;
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstbusy_late_ack got rdata_valid=%b exp 0", rdata_valid);
        end
        @(posedge clk);
        #1;
        req_cnt = 0;
        manual_ack = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_stores();
        test_load_ext();
        test_rejects();
        test_non_access();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_busy();
        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
